aes_frame_ctrl: RTL

AES_FRAME_CTRL -- requirements
Module: aes_frame_ctrl

---
 rtl/aes_frame_ctrl_pkg.sv | 36 +++
 rtl/aes_hs_timer.sv | 27 ++
 rtl/aes_frame_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aes_frame_ctrl_pkg.sv
// Shared definitions for the I2C-frame to AES-core controller: frame layout,
// state encoding, error codes and the key-cache hit helper.
package aes_frame_ctrl_pkg;

  localparam logic [7:0] ADDR_BYTE = 8'hD4;

  localparam int FRAME_W  = 264;
  localparam int ADDR_MSB = 263;
  localparam int KEY_MSB  = 255;
  localparam int PT_MSB   = 127;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_KEY_LOAD  = 3'd2,
    ST_KEY_WAIT  = 3'd3,
    ST_ENC_START = 3'd4,
    ST_ENC_WAIT  = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ADDR   = 2'd1,
    ERR_KEY_TO = 2'd2,
    ERR_ENC_TO = 2'd3
  } err_t;

  // A previously expanded key can be reused only while the cache is valid.
  function automatic logic key_hit(input logic valid,
                                   input logic [127:0] cached,
                                   input logic [127:0] captured);
    return valid && (cached == captured);
  endfunction

endpackage

// File: rtl/aes_hs_timer.sv
// Saturating 8-bit handshake timer shared by the key and encryption wait states.
module aes_hs_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // Count wait cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count >= LIMIT);

endmodule

// File: rtl/aes_frame_ctrl.sv
// Accepts a 33-byte I2C frame, checks the address, loads the key (skipping it on
// a cache hit), runs one encryption and latches the ciphertext.
module aes_frame_ctrl
  import aes_frame_ctrl_pkg::*;
#(
  parameter logic [7:0]  ADDR_BYTE = aes_frame_ctrl_pkg::ADDR_BYTE,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_done,
  output logic [127:0]       key_out,
  output logic [127:0]       block_out,
  output logic               key_load,
  input  logic               key_ready,
  output logic               enc_start,
  input  logic               enc_done,
  input  logic [127:0]       enc_result,
  output logic [127:0]       result,
  output logic               result_valid,
  output logic               busy,
  output logic [1:0]         err
);

  state_t       state;
  logic         frame_done_q;
  logic         frame_rise;
  logic [7:0]   frame_addr;
  logic [127:0] frame_key;
  logic [127:0] frame_pt;
  logic [127:0] cached_key;
  logic         cache_valid;
  logic         in_wait;
  logic         timer_expired;

  assign frame_rise = frame_done && !frame_done_q;
  assign in_wait    = (state == ST_KEY_WAIT) || (state == ST_ENC_WAIT);

  aes_hs_timer #(
    .LIMIT (8'(TIMEOUT))
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (timer_expired)
  );

  // Control FSM; every output is registered and updated with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      frame_done_q <= 1'b0;
      frame_addr   <= 8'd0;
      frame_key    <= 128'd0;
      frame_pt     <= 128'd0;
      cached_key   <= 128'd0;
      cache_valid  <= 1'b0;
      key_out      <= 128'd0;
      block_out    <= 128'd0;
      key_load     <= 1'b0;
      enc_start    <= 1'b0;
      result       <= 128'd0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= ERR_NONE;
    end else begin
      frame_done_q <= frame_done;
      key_load     <= 1'b0;
      enc_start    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_rise) begin
            frame_addr   <= frame_data[ADDR_MSB -: 8];
            frame_key    <= frame_data[KEY_MSB -: 128];
            frame_pt     <= frame_data[PT_MSB -: 128];
            result_valid <= 1'b0;
            err          <= ERR_NONE;
            busy         <= 1'b1;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_addr != ADDR_BYTE) begin
            err   <= ERR_ADDR;
            state <= ST_FAULT;
          end else if (key_hit(cache_valid, cached_key, frame_key)) begin
            block_out <= frame_pt;
            enc_start <= 1'b1;
            state     <= ST_ENC_START;
          end else begin
            key_out  <= frame_key;
            key_load <= 1'b1;
            state    <= ST_KEY_LOAD;
          end
        end
        ST_KEY_LOAD: begin
          state <= ST_KEY_WAIT;
        end
        // key_ready is tested first so it wins over a same-cycle timeout.
        ST_KEY_WAIT: begin
          if (key_ready) begin
            cached_key  <= frame_key;
            cache_valid <= 1'b1;
            block_out   <= frame_pt;
            enc_start   <= 1'b1;
            state       <= ST_ENC_START;
          end else if (timer_expired) begin
            cache_valid <= 1'b0;
            err         <= ERR_KEY_TO;
            state       <= ST_FAULT;
          end
        end
        ST_ENC_START: begin
          state <= ST_ENC_WAIT;
        end
        ST_ENC_WAIT: begin
          if (enc_done) begin
            result       <= enc_result;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else if (timer_expired) begin
            err   <= ERR_ENC_TO;
            state <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
